// File: rtl/operand_pair_buffer_if.sv
// Handshake bundle for operand_pair_buffer: the word stream in, the operand-pair stream out.
// The slave modport is the buffer itself; the master modport is whoever drives words and consumes pairs.
interface operand_pair_buffer_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [LVL_W-1:0] level;

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  m_ready,
        output s_ready,
        output m_valid,
        output in0,
        output in1,
        output level
    );

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  in0,
        input  in1,
        input  level
    );
endinterface

// File: rtl/operand_pair_buffer.sv
// Pairs consecutive stream words into (in0, in1) operands and queues them in a DEPTH-entry FIFO.
// Optional pad-pair counter enabled by defining OPERAND_PAIR_STATS_EN (adds output pad_count).
module operand_pair_buffer #(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    operand_pair_buffer_if.slave      bus
`ifdef OPERAND_PAIR_STATS_EN
    ,
    output logic [15:0]               pad_count
`endif
);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int PAIR_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_PAD    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    hold_q, hold_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                m_valid_q, m_valid_d;
    logic [WIDTH-1:0]    in0_q, in0_d;
    logic [WIDTH-1:0]    in1_q, in1_d;

    logic [PAIR_W-1:0]   mem [DEPTH];

    logic                pop;
    logic                full;
    logic                space;
    logic                s_ready;
    logic                push;
    logic [PAIR_W-1:0]   push_data;
    logic [LVL_W-1:0]    remain;
    logic [PAIR_W-1:0]   head_d;

    // Handshake qualifiers and the pairing FSM next-state logic.
    always_comb begin
        pop       = m_valid_q && bus.m_ready;
        full      = (level_q == LVL_W'(DEPTH));
        space     = !full || pop;
        s_ready   = 1'b0;
        push      = 1'b0;
        push_data = '0;
        state_d   = state_q;
        hold_d    = hold_q;
        case (state_q)
            S_FIRST: begin
                s_ready = 1'b1;
                if (bus.s_valid) begin
                    hold_d  = bus.s_data;
                    state_d = bus.s_last ? S_PAD : S_SECOND;
                end
            end
            S_SECOND: begin
                s_ready = space;
                if (bus.s_valid && space) begin
                    push      = 1'b1;
                    push_data = {hold_q, bus.s_data};
                    state_d   = S_FIRST;
                end
            end
            S_PAD: begin
                if (space) begin
                    push      = 1'b1;
                    push_data = {hold_q, PAD_VALUE};
                    state_d   = S_FIRST;
                end
            end
            default: begin
                state_d = S_FIRST;
            end
        endcase
    end

    // FIFO bookkeeping plus the registered view of the next head entry.
    // When nothing older survives this edge, the pair being pushed becomes the head.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
        remain    = level_q - LVL_W'(pop);
        head_d    = '0;
        if (level_d == '0) begin
            head_d = '0;
        end else if (remain == '0) begin
            head_d = push_data;
        end else begin
            head_d = mem[rd_ptr_d];
        end
        m_valid_d = (level_d != '0);
        in0_d     = head_d[PAIR_W-1:WIDTH];
        in1_d     = head_d[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FIRST;
            hold_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            m_valid_q <= 1'b0;
            in0_q     <= '0;
            in1_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            m_valid_q <= m_valid_d;
            in0_q     <= in0_d;
            in1_q     <= in1_d;
        end
    end

`ifdef OPERAND_PAIR_STATS_EN
    logic [15:0] pad_count_q, pad_count_d;

    always_comb begin
        pad_count_d = pad_count_q;
        if (push && (state_q == S_PAD) && (pad_count_q != 16'hFFFF)) begin
            pad_count_d = pad_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pad_count_q <= '0;
        end else begin
            pad_count_q <= pad_count_d;
        end
    end

    assign pad_count = pad_count_q;
`endif

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.in0     = in0_q;
    assign bus.in1     = in1_q;
    assign bus.level   = level_q;
endmodule

// File: tb/tb_operand_pair_buffer.sv
// Directed bench for operand_pair_buffer: hand-written reset sequence, then a vector table
// covering pairing, odd-length padding, backpressure, push/pop at full and padding while full.
module tb_operand_pair_buffer;
    logic clock;
    logic reset_n;

    operand_pair_buffer_if #(.WIDTH(4), .DEPTH(2)) bus ();

`ifdef OPERAND_PAIR_STATS_EN
    logic [15:0] pad_count;
`endif

    operand_pair_buffer #(
        .WIDTH    (4),
        .DEPTH    (2),
        .PAD_VALUE(4'h0)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
`ifdef OPERAND_PAIR_STATS_EN
        ,
        .pad_count(pad_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       l;
        logic       mr;
        logic       e_sr;
        logic       e_mv;
        logic [3:0] e_in0;
        logic [3:0] e_in1;
        logic [1:0] e_lvl;
    } vec_t;

    vec_t vecs [26];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    function automatic vec_t mk(logic v, logic [3:0] d, logic l, logic mr, logic e_sr,
                                logic e_mv, logic [3:0] e_in0, logic [3:0] e_in1,
                                logic [1:0] e_lvl);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.mr = mr; r.e_sr = e_sr;
        r.e_mv = e_mv; r.e_in0 = e_in0; r.e_in1 = e_in1; r.e_lvl = e_lvl;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic drive(logic v, logic [3:0] d, logic l, logic mr);
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.m_ready = mr;
    endtask

    task automatic apply(logic v, logic [3:0] d, logic l, logic mr);
        drive(v, d, l, mr);
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Each row: inputs for one cycle, s_ready before the edge, outputs after it.
        //              v     d     l     mr    sr    mv    in0   in1   lvl
        vecs[0]  = mk(1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
        vecs[1]  = mk(1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 4'h5, 2'd1);
        vecs[2]  = mk(1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
        vecs[3]  = mk(1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 2'd1);
        vecs[4]  = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
        vecs[5]  = mk(1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
        vecs[6]  = mk(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 4'h0, 2'd1);
        vecs[7]  = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
        vecs[8]  = mk(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
        vecs[9]  = mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h2, 2'd1);
        vecs[10] = mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h2, 2'd1);
        vecs[11] = mk(1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h2, 2'd2);
        vecs[12] = mk(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h2, 2'd2);
        vecs[13] = mk(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 4'h2, 2'd2);
        vecs[14] = mk(1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 4'h4, 2'd2);
        vecs[15] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 4'h6, 2'd1);
        vecs[16] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
        vecs[17] = mk(1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'd0);
        vecs[18] = mk(1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 4'h9, 2'd1);
        vecs[19] = mk(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 4'h9, 2'd1);
        vecs[20] = mk(1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 4'h9, 2'd2);
        vecs[21] = mk(1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 4'h8, 4'h9, 2'd2);
        vecs[22] = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h8, 4'h9, 2'd2);
        vecs[23] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 4'hB, 2'd2);
        vecs[24] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 4'h0, 2'd1);
        vecs[25] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 2'd0);

        reset_n = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        chk("reset_level",   32'(bus.level),   32'd0);
        chk("reset_m_valid", 32'(bus.m_valid), 32'd0);
        chk("reset_in0",     32'(bus.in0),     32'd0);
        chk("reset_in1",     32'(bus.in1),     32'd0);
        chk("reset_s_ready", 32'(bus.s_ready), 32'd1);
`ifdef OPERAND_PAIR_STATS_EN
        chk("reset_pad_count", 32'(pad_count), 32'd0);
`endif

        // Reset mid-operation: a stored pair and a half-formed pair must both vanish.
        apply(1'b1, 4'h1, 1'b0, 1'b0);
        apply(1'b1, 4'h2, 1'b0, 1'b0);
        chk("pre_reset_level", 32'(bus.level), 32'd1);
        apply(1'b1, 4'h3, 1'b0, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_level",   32'(bus.level),   32'd0);
        chk("async_reset_m_valid", 32'(bus.m_valid), 32'd0);
        chk("async_reset_in0",     32'(bus.in0),     32'd0);
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        apply(1'b1, 4'h5, 1'b0, 1'b0);
        apply(1'b1, 4'h6, 1'b0, 1'b0);
        chk("post_reset_m_valid", 32'(bus.m_valid), 32'd1);
        chk("post_reset_in0",     32'(bus.in0),     32'h5);
        chk("post_reset_in1",     32'(bus.in1),     32'h6);
        chk("post_reset_level",   32'(bus.level),   32'd1);
        apply(1'b0, 4'h0, 1'b0, 1'b1);
        chk("post_reset_drain", 32'(bus.level), 32'd0);

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].mr);
            #4;
            chk($sformatf("v%0d_s_ready", i), 32'(bus.s_ready), 32'(vecs[i].e_sr));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_m_valid", i), 32'(bus.m_valid), 32'(vecs[i].e_mv));
            chk($sformatf("v%0d_in0", i),     32'(bus.in0),     32'(vecs[i].e_in0));
            chk($sformatf("v%0d_in1", i),     32'(bus.in1),     32'(vecs[i].e_in1));
            chk($sformatf("v%0d_level", i),   32'(bus.level),   32'(vecs[i].e_lvl));
            $display("vec %0d: v=%0b d=%0h l=%0b mr=%0b -> s_ready=%0b m_valid=%0b in0=%0h in1=%0h level=%0d",
                     i, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].mr, bus.s_ready,
                     bus.m_valid, bus.in0, bus.in1, bus.level);
        end

`ifdef OPERAND_PAIR_STATS_EN
        chk("pad_count_final", 32'(pad_count), 32'd2);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
